cache_mem_responder: RTL and testbench

CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

---
 rtl/cache_pkg.sv | 13 +
 rtl/mem_array.sv | 41 ++++
 rtl/cache_mem_responder.sv | 178 +++++++++++++++++
 tb/tb_cache_mem_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths and responder state encoding for the cache line memory responder.
package cache_pkg;
  localparam int WORD_W     = 64;
  localparam int ADDR_W     = 32;
  localparam int LINE_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RD_BURST,
    WR_BURST
  } rsp_state_e;
endpackage

// File: rtl/mem_array.sv
// Word storage: combinational read, synchronous write (write port only with CACHE_MEM_WRITEBACK_EN).
// Contents start as word[i] = i*i and are never cleared by reset.
module mem_array
  import cache_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = 12
) (
  input  logic [AW-1:0]     i_raddr,
`ifdef CACHE_MEM_WRITEBACK_EN
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
`endif
  output logic [WORD_W-1:0] o_rdata
);

  typedef logic [WORD_W-1:0] mem_t [DEPTH_WORDS];

  function automatic mem_t f_squares();
    mem_t m;
    for (int i = 0; i < DEPTH_WORDS; i++) begin
      m[i] = WORD_W'(i) * WORD_W'(i);
    end
    return m;
  endfunction

  mem_t r_mem = f_squares();

  assign o_rdata = r_mem[i_raddr];

`ifdef CACHE_MEM_WRITEBACK_EN
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end
`endif

endmodule

// File: rtl/cache_mem_responder.sv
// Cache line responder: 4-word critical-word-first read bursts after a fixed latency.
// Line write-back bursts are available when CACHE_MEM_WRITEBACK_EN is defined.
module cache_mem_responder
  import cache_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_err,
  input  logic              wr_valid,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              wr_done
);

  localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_INIT  = 4'(LATENCY - 1);
  localparam logic [1:0] LAST_BEAT = 2'(LINE_WORDS - 1);

  rsp_state_e        r_state;
  rsp_state_e        w_state_nxt;
  logic [ADDR_W-4:0] r_base;
  logic [1:0]        r_off;
  logic [1:0]        r_beat;
  logic [3:0]        r_lat;
  logic              r_err;

  logic [ADDR_W-4:0] w_word;
  logic [ADDR_W-4:0] w_base;
  logic              w_err_acc;
  logic              w_is_write;
  logic [1:0]        w_col;
  logic [AW-1:0]     w_mem_addr;
  logic [WORD_W-1:0] w_rdata;
  logic              w_wr_ready;
  logic              w_unused;

  assign w_word    = req_addr[ADDR_W-1:3];
  assign w_base    = {w_word[ADDR_W-4:2], 2'b00};
  assign w_err_acc = (ADDR_W'(w_base) + ADDR_W'(LINE_WORDS - 1)) >= ADDR_W'(DEPTH_WORDS);

  // Wrap within the line: only the two low word-index bits walk.
  assign w_col      = r_off + r_beat;
  assign w_mem_addr = AW'({r_base[ADDR_W-4:2], w_col});

`ifdef CACHE_MEM_WRITEBACK_EN
  logic r_wr_done;
  assign w_is_write = req_write;
  assign wr_ready   = w_wr_ready;
  assign wr_done    = r_wr_done;
  assign w_unused   = ^{req_addr[2:0], w_wr_ready};
`else
  assign w_is_write = 1'b0;
  assign wr_ready   = 1'b0;
  assign wr_done    = 1'b0;
  assign w_unused   = ^{req_addr[2:0], req_write, wr_valid, wr_data, w_wr_ready};
`endif

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_last    = 1'b0;
    w_wr_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_nxt = w_is_write ? WR_BURST : WAIT;
        end
      end
      WAIT: begin
        if (r_lat == 4'd0) begin
          w_state_nxt = RD_BURST;
        end
      end
      RD_BURST: begin
        rsp_valid = 1'b1;
        rsp_last  = (r_beat == LAST_BEAT);
        if (rsp_ready && (r_beat == LAST_BEAT)) begin
          w_state_nxt = IDLE;
        end
      end
      WR_BURST: begin
        w_wr_ready = 1'b1;
`ifdef CACHE_MEM_WRITEBACK_EN
        if (wr_valid && (r_beat == LAST_BEAT)) begin
          w_state_nxt = IDLE;
        end
`else
        w_state_nxt = IDLE;
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Out-of-range lines never touch storage: data forced to zero, error flagged.
  assign rsp_err  = rsp_valid && r_err;
  assign rsp_data = (rsp_valid && !r_err) ? w_rdata : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_off   <= '0;
      r_beat  <= '0;
      r_lat   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_base <= w_base;
            r_off  <= w_word[1:0];
            r_beat <= '0;
            r_lat  <= w_is_write ? 4'd0 : LAT_INIT;
            r_err  <= w_err_acc;
          end
        end
        WAIT: begin
          if (r_lat != 4'd0) begin
            r_lat <= r_lat - 4'd1;
          end
        end
        RD_BURST: begin
          if (rsp_ready) begin
            r_beat <= r_beat + 2'd1;
          end
        end
        WR_BURST: begin
`ifdef CACHE_MEM_WRITEBACK_EN
          if (wr_valid) begin
            r_beat <= r_beat + 2'd1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_MEM_WRITEBACK_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_done <= 1'b0;
    end else begin
      r_wr_done <= (r_state == WR_BURST) && wr_valid && (r_beat == LAST_BEAT);
    end
  end
`endif

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_mem (
    .i_raddr(w_mem_addr),
`ifdef CACHE_MEM_WRITEBACK_EN
    .i_clk  (clock),
    .i_we   ((r_state == WR_BURST) && wr_valid && !r_err),
    .i_waddr(w_mem_addr),
    .i_wdata(wr_data),
`endif
    .o_rdata(w_rdata)
  );

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder (LATENCY=4, DEPTH_WORDS=4096).
module tb_cache_mem_responder;
  localparam int LAT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic        wr_valid;
  logic [63:0] wr_data;
  logic        wr_ready;
  logic        wr_done;

  int n_tests = 0;
  int n_fail  = 0;

  cache_mem_responder #(.DEPTH_WORDS(4096), .LATENCY(LAT)) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_write(req_write),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_last (rsp_last),
    .rsp_err  (rsp_err),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .wr_done  (wr_done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic wr,
                         input logic [63:0] e0, input logic [63:0] e1,
                         input logic [63:0] e2, input logic [63:0] e3,
                         input logic err, input int stall_beat, input int stall_n,
                         input logic hold, input logic [31:0] hold_addr);
    logic [63:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr;
    chk("req_ready_idle", req_ready, 1);
    tick();
    if (hold) req_addr = hold_addr;
    else      req_valid = 1'b0;
    req_write = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      chk($sformatf("wait%0d_rsp_valid", k), rsp_valid, 0);
      chk($sformatf("wait%0d_req_ready", k), req_ready, 0);
      tick();
    end
    for (int b = 0; b < 4; b++) begin
      if (b == stall_beat) begin
        rsp_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          chk($sformatf("stall%0d_valid", s), rsp_valid, 1);
          chk($sformatf("stall%0d_data", s), rsp_data, exp[b]);
          chk($sformatf("stall%0d_last", s), rsp_last, (b == 3));
          tick();
        end
        rsp_ready = 1'b1;
      end
      chk($sformatf("beat%0d_valid", b), rsp_valid, 1);
      chk($sformatf("beat%0d_data", b), rsp_data, exp[b]);
      chk($sformatf("beat%0d_last", b), rsp_last, (b == 3));
      chk($sformatf("beat%0d_err", b), rsp_err, err);
      chk($sformatf("beat%0d_wr_ready", b), wr_ready, 0);
      tick();
    end
    chk("end_req_ready", req_ready, 1);
    chk("end_rsp_valid", rsp_valid, 0);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_req_ready"}, req_ready, 1);
    chk({pfx, "_rsp_valid"}, rsp_valid, 0);
    chk({pfx, "_rsp_data"},  rsp_data,  0);
    chk({pfx, "_rsp_last"},  rsp_last,  0);
    chk({pfx, "_rsp_err"},   rsp_err,   0);
    chk({pfx, "_wr_ready"},  wr_ready,  0);
    chk({pfx, "_wr_done"},   wr_done,   0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    rsp_ready = 1'b1;
    wr_valid  = 1'b0;
    wr_data   = '0;
    repeat (3) tick();
    chk_reset_outputs("por");
    reset = 1'b1;
    tick();

    // addr 16: W=2, S=2 -> words 2,3,0,1
    do_read(32'd16, 1'b0, 64'd4, 64'd9, 64'd0, 64'd1, 1'b0, -1, 0, 1'b0, 32'd0);
    // addr 40: W=5, S=1 -> words 5,6,7,4 with a 3-cycle stall on beat 1
    do_read(32'd40, 1'b0, 64'd25, 64'd36, 64'd49, 64'd16, 1'b0, 1, 3, 1'b0, 32'd0);
    // last in-range line, critical word 4095
    do_read(32'd32767, 1'b0, 64'd16769025, 64'd16744464, 64'd16752649, 64'd16760836,
            1'b0, -1, 0, 1'b0, 32'd0);
    do_read(32'd32768, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 2, 2, 1'b0, 32'd0);

    // Request held high with a new address during the in-flight read is ignored.
    do_read(32'd8, 1'b0, 64'd1, 64'd4, 64'd9, 64'd0, 1'b0, -1, 0, 1'b1, 32'd16);
    do_read(32'd16, 1'b0, 64'd4, 64'd9, 64'd0, 64'd1, 1'b0, -1, 0, 1'b0, 32'd0);

    // Reset in the middle of a read burst, after beat 1 handshakes.
    req_valid = 1'b1;
    req_addr  = 32'd0;
    tick();
    req_valid = 1'b0;
    repeat (LAT) tick();
    chk("rst_beat0_data", rsp_data, 0);
    tick();
    chk("rst_beat1_data", rsp_data, 1);
    tick();
    chk("rst_beat2_data", rsp_data, 4);
    reset = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    tick();
    reset = 1'b1;
    tick();
    do_read(32'd0, 1'b0, 64'd0, 64'd1, 64'd4, 64'd9, 1'b0, -1, 0, 1'b0, 32'd0);

`ifdef CACHE_MEM_WRITEBACK_EN
    // Write-back of line 0 starting at word 1, then read it back from word 0.
    req_valid = 1'b1;
    req_addr  = 32'd8;
    req_write = 1'b1;
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
    chk("wr_req_ready", req_ready, 0);
    for (int b = 0; b < 4; b++) begin
      wr_valid = 1'b1;
      wr_data  = 64'hA + 64'(b);
      chk($sformatf("wr%0d_ready", b), wr_ready, 1);
      chk($sformatf("wr%0d_done", b), wr_done, 0);
      tick();
    end
    wr_valid = 1'b0;
    chk("wr_done_pulse", wr_done, 1);
    chk("wr_done_idle", req_ready, 1);
    chk("wr_done_wr_ready", wr_ready, 0);
    tick();
    chk("wr_done_clear", wr_done, 0);
    do_read(32'd0, 1'b0, 64'hD, 64'hA, 64'hB, 64'hC, 1'b0, -1, 0, 1'b0, 32'd0);
`else
    // Write requests are served as reads: addr 24 -> W=3, S=3 -> words 3,0,1,2
    wr_valid = 1'b1;
    wr_data  = 64'hDEAD;
    do_read(32'd24, 1'b1, 64'd9, 64'd0, 64'd1, 64'd4, 1'b0, -1, 0, 1'b0, 32'd0);
    chk("nowb_wr_done", wr_done, 0);
    wr_valid = 1'b0;
    do_read(32'd24, 1'b0, 64'd9, 64'd0, 64'd1, 64'd4, 1'b0, -1, 0, 1'b0, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
